// File: rtl/gray_step_sched.sv
// Step scheduler for a downstream Gray counter: round-robin arbitration between two
// requesters, optional counter clear, then a burst of increment enables per job.
module gray_step_sched #(
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [STEP_W-1:0] req0_steps,
    input  logic              req0_clear,
    input  logic              req1_valid,
    input  logic [STEP_W-1:0] req1_steps,
    input  logic              req1_clear,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              cnt_rst,
    output logic              cnt_en,
    output logic              busy,
    output logic              grant_id,
    output logic [STEP_W-1:0] steps_left,
    output logic              done_valid,
    output logic              done_id
);

    typedef enum logic [1:0] {IDLE, CLEAR, STEP, DONE} state_t;

    state_t            state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic              grant_id_nxt;
    logic [STEP_W-1:0] steps_left_nxt;
    logic              win0, win1;
    logic              sel;
    logic              sel_clear;
    logic [STEP_W-1:0] sel_steps;

    // On a tie the requester that did not win last time gets the grant.
    assign win0 = req0_valid & (~req1_valid | last_grant);
    assign win1 = req1_valid & (~req0_valid | ~last_grant);

    assign req0_ready = (state == IDLE) & win0;
    assign req1_ready = (state == IDLE) & win1;
    assign cnt_rst    = (state == CLEAR);
    assign cnt_en     = (state == STEP);
    assign busy       = (state != IDLE);
    assign done_valid = (state == DONE);
    assign done_id    = grant_id;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_id_nxt   = grant_id;
        steps_left_nxt = steps_left;
        sel            = win1;
        sel_clear      = win1 ? req1_clear : req0_clear;
        sel_steps      = win1 ? req1_steps : req0_steps;
        case (state)
            IDLE: begin
                if (win0 | win1) begin
                    grant_id_nxt   = sel;
                    last_grant_nxt = sel;
                    steps_left_nxt = sel_steps;
                    if (sel_clear)
                        state_nxt = CLEAR;
                    else if (sel_steps != '0)
                        state_nxt = STEP;
                    else
                        state_nxt = DONE;
                end
            end
            CLEAR: begin
                state_nxt = (steps_left != '0) ? STEP : DONE;
            end
            STEP: begin
                // steps_left is never zero here; the guard only keeps it from wrapping.
                if (steps_left != '0)
                    steps_left_nxt = steps_left - STEP_W'(1);
                if (steps_left <= STEP_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            steps_left <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_id_nxt;
            steps_left <= steps_left_nxt;
        end
    end

endmodule

// File: tb/tb_gray_step_sched.sv
// Scoreboard bench for gray_step_sched: directed jobs push expected completions,
// a monitor pops them on done_valid and checks owner, timing and the Gray count.
module tb_gray_step_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_steps, req1_steps;
    logic       req0_clear, req1_clear;
    logic       req0_ready, req1_ready;
    logic       cnt_rst, cnt_en, busy, grant_id, done_valid, done_id;
    logic [3:0] steps_left;

    gray_step_sched #(.STEP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_steps(req0_steps), .req0_clear(req0_clear),
        .req1_valid(req1_valid), .req1_steps(req1_steps), .req1_clear(req1_clear),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .cnt_rst(cnt_rst), .cnt_en(cnt_en), .busy(busy), .grant_id(grant_id),
        .steps_left(steps_left), .done_valid(done_valid), .done_id(done_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream Gray counter as it would be driven by cnt_rst/cnt_en.
    logic [3:0] gbin = 4'd0;
    always @(posedge clk) begin
        if (rst || cnt_rst) gbin <= 4'd0;
        else if (cnt_en)    gbin <= gbin + 4'd1;
    end

    typedef struct {
        int id;
        int lat;
        int n_en;
        int first;
        int n_rst;
        int gray;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input int lat, input int n_en, input int first,
                        input int n_rst, input int gray);
        exp_t e;
        e.id = id; e.lat = lat; e.n_en = n_en; e.first = first; e.n_rst = n_rst; e.gray = gray;
        sb.push_back(e);
    endtask

    // Monitor: tracks the job since acceptance and checks it when done_valid appears.
    bit acc_vld = 1'b0;
    int acc_cyc, en_cnt, rst_cnt, first_en;
    always @(negedge clk) begin
        if (rst) begin
            acc_vld = 1'b0;
        end else begin
            if (acc_vld) begin
                if (cnt_en) begin
                    en_cnt++;
                    if (first_en == 0) first_en = cyc - acc_cyc;
                end
                if (cnt_rst) rst_cnt++;
            end
            if (cnt_en && cnt_rst) chk("en_rst_overlap", 1, 0);
            if (busy && (req0_ready || req1_ready)) chk("ready_while_busy", 1, 0);
            if (req0_ready && req1_ready) chk("dual_ready", 1, 0);
            if (done_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_id", int'(done_id), e.id);
                    chk("done_latency", acc_vld ? cyc - acc_cyc : -1, e.lat);
                    chk("cnt_en_cycles", en_cnt, e.n_en);
                    chk("first_en_offset", first_en, e.first);
                    chk("cnt_rst_cycles", rst_cnt, e.n_rst);
                    chk("gray_at_done", int'(gbin ^ (gbin >> 1)), e.gray);
                    chk("steps_left_at_done", int'(steps_left), 0);
                end
                acc_vld = 1'b0;
            end
            if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin
                acc_vld  = 1'b1;
                acc_cyc  = cyc;
                en_cnt   = 0;
                rst_cnt  = 0;
                first_en = 0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == 60) chk("idle_timeout", 1, 0);
    endtask

    task automatic send(input bit id, input int steps, input bit clr);
        int k;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_steps = 4'(steps); req1_clear = clr; end
        else    begin req0_valid = 1'b1; req0_steps = 4'(steps); req0_clear = clr; end
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
        end
        if (k == 20) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        int acc[4];
        int k, en_seen;
        rst = 1'b1;
        req0_valid = 1'b0; req0_steps = 4'd0; req0_clear = 1'b0;
        req1_valid = 1'b0; req1_steps = 4'd0; req1_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_steps_left", steps_left, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_cnt_rst", cnt_rst, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_ready0", req0_ready, 0);

        // Single jobs: id, latency, enables, first-enable offset, clears, Gray at done.
        push(0, 4, 3, 1, 0, 4'b0010);  send(0, 3, 1'b0);   // bin 3
        push(1, 4, 2, 2, 1, 4'b0011);  send(1, 2, 1'b1);   // bin 2
        push(0, 1, 0, 0, 0, 4'b0011);  send(0, 0, 1'b0);   // bin 2

        // Both requesters held valid with steps=1: strict alternation, 3 cycles apart.
        do_reset();
        push(0, 2, 1, 1, 0, 4'b0001);
        push(1, 2, 1, 1, 0, 4'b0011);
        push(0, 2, 1, 1, 0, 4'b0010);
        push(1, 2, 1, 1, 0, 4'b0110);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_steps = 4'd1; req0_clear = 1'b0;
        req1_valid = 1'b1; req1_steps = 4'd1; req1_clear = 1'b0;
        for (int j = 0; j < 4; j++) begin
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) break;
            end
            if (k == 20) chk("rr_accept_timeout", 1, 0);
            acc[j] = cyc;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int j = 1; j < 4; j++) chk("rr_spacing", acc[j] - acc[j-1], 3);
        wait_idle();

        // Abort a long job with rst during its 5th enable cycle.
        do_reset();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_steps = 4'd15; req0_clear = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        if (k == 20) chk("abort_accept_timeout", 1, 0);
        @(posedge clk); #1 req0_valid = 1'b0;
        en_seen = 0;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cnt_en) en_seen++;
            if (en_seen == 5) break;
        end
        chk("abort_en_seen", en_seen, 5);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_cnt_en", cnt_en, 0);
        chk("abort_cnt_rst", cnt_rst, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done_valid, 0);
        chk("abort_steps_left", steps_left, 0);

        // First tie after the abort goes to requester 0.
        push(0, 2, 1, 1, 0, 4'b0001);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_steps = 4'd1; req0_clear = 1'b0;
        req1_valid = 1'b1; req1_steps = 4'd1; req1_clear = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) break;
        end
        chk("tie_ready0", req0_ready, 1);
        chk("tie_ready1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Maximum step count, with and without a clear.
        push(0, 17, 15, 2, 1, 4'b1000); send(0, 15, 1'b1);   // bin 15
        push(1, 16, 15, 1, 0, 4'b1001); send(1, 15, 1'b0);   // bin 14

        for (k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
